// File: rtl/patgen_pkg.sv
// Shared definitions for the video pattern generator: default 720x480 timing,
// pattern_sel encodings and the colour-bar table.
package patgen_pkg;

   localparam int DEF_H_SYNCLEN   = 62;
   localparam int DEF_H_BACKPORCH = 60;
   localparam int DEF_H_ACTIVE    = 720;
   localparam int DEF_H_TOTAL     = 858;
   localparam int DEF_V_SYNCLEN   = 6;
   localparam int DEF_V_BACKPORCH = 30;
   localparam int DEF_V_ACTIVE    = 480;
   localparam int DEF_V_TOTAL     = 525;
   localparam int DEF_BAR_W       = 90;
   localparam int DEF_GRID        = 32;
   localparam int DEF_RAMP_SHIFT  = 1;

   typedef enum logic [1:0] {
      PAT_RAMP   = 2'd0,
      PAT_BARS   = 2'd1,
      PAT_SOLID  = 2'd2,
      PAT_XHATCH = 2'd3
   } pat_e;

   // Index 0 is the left-most bar: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [7:0][23:0] BAR_TABLE = {
      24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
      24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
   };

   function automatic logic sync_level(input logic asserted, input logic pol);
      return asserted ? pol : ~pol;
   endfunction

endpackage

// File: rtl/patgen_timing.sv
// Raster counters plus registered sync, data-enable, frame-start and frame counter.
// Also exposes the live counter state so pattern logic can stay aligned.
module patgen_timing
   import patgen_pkg::*;
#(
   parameter int H_SYNCLEN   = DEF_H_SYNCLEN,
   parameter int H_BACKPORCH = DEF_H_BACKPORCH,
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_TOTAL     = DEF_H_TOTAL,
   parameter int V_SYNCLEN   = DEF_V_SYNCLEN,
   parameter int V_BACKPORCH = DEF_V_BACKPORCH,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_TOTAL     = DEF_V_TOTAL,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0,
   parameter int HW          = $clog2(H_TOTAL),
   parameter int VW          = $clog2(V_TOTAL)
)(
   input  logic          i_clk,
   input  logic          i_rst_n,
   output logic [HW-1:0] o_h_cnt,
   output logic [VW-1:0] o_v_cnt,
   output logic          o_line_end,
   output logic          o_frame_end,
   output logic          o_active,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic          o_de,
   output logic          o_frame_start,
   output logic [7:0]    o_frame_cnt
);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW:0]   H_SYNC_END = (HW+1)'(H_SYNCLEN);
   localparam logic [HW:0]   H_ACT_BEG  = (HW+1)'(H_SYNCLEN + H_BACKPORCH);
   localparam logic [HW:0]   H_ACT_END  = (HW+1)'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
   localparam logic [VW:0]   V_SYNC_END = (VW+1)'(V_SYNCLEN);
   localparam logic [VW:0]   V_ACT_BEG  = (VW+1)'(V_SYNCLEN + V_BACKPORCH);
   localparam logic [VW:0]   V_ACT_END  = (VW+1)'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);

   logic [HW-1:0] r_h_cnt;
   logic [VW-1:0] r_v_cnt;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_de;
   logic          r_frame_start;
   logic [7:0]    r_frame_cnt;

   logic [HW:0]   w_h_ext;
   logic [VW:0]   w_v_ext;
   logic          w_line_end;
   logic          w_frame_end;
   logic          w_h_act;
   logic          w_v_act;
   logic          w_active;
   logic          w_origin;

   // One extra bit keeps the end-of-region compares valid when a region ends at the total.
   assign w_h_ext     = {1'b0, r_h_cnt};
   assign w_v_ext     = {1'b0, r_v_cnt};
   assign w_line_end  = (r_h_cnt == H_LAST);
   assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);
   assign w_h_act     = (w_h_ext >= H_ACT_BEG) && (w_h_ext < H_ACT_END);
   assign w_v_act     = (w_v_ext >= V_ACT_BEG) && (w_v_ext < V_ACT_END);
   assign w_active    = w_h_act && w_v_act;
   assign w_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_de          <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
      end else begin
         r_h_cnt <= w_line_end ? '0 : r_h_cnt + 1'b1;
         if (w_line_end) begin
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
         end
         r_hsync       <= sync_level(w_h_ext < H_SYNC_END, HSYNC_POL);
         r_vsync       <= sync_level(w_v_ext < V_SYNC_END, VSYNC_POL);
         r_de          <= w_active;
         r_frame_start <= w_origin;
         if (w_origin) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign o_h_cnt       = r_h_cnt;
   assign o_v_cnt       = r_v_cnt;
   assign o_line_end    = w_line_end;
   assign o_frame_end   = w_frame_end;
   assign o_active      = w_active;
   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_de          = r_de;
   assign o_frame_start = r_frame_start;
   assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: rtl/patgen.sv
// Test-pattern generator: ramp, colour bars, solid colour and crosshatch over a
// raster from patgen_timing; mode and colour change only at frame boundaries.
module patgen
   import patgen_pkg::*;
#(
   parameter int H_SYNCLEN   = DEF_H_SYNCLEN,
   parameter int H_BACKPORCH = DEF_H_BACKPORCH,
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_TOTAL     = DEF_H_TOTAL,
   parameter int V_SYNCLEN   = DEF_V_SYNCLEN,
   parameter int V_BACKPORCH = DEF_V_BACKPORCH,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_TOTAL     = DEF_V_TOTAL,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0,
   parameter int BAR_W       = DEF_BAR_W,
   parameter int GRID        = DEF_GRID,
   parameter int RAMP_SHIFT  = DEF_RAMP_SHIFT
)(
   input  logic        clk27,
   input  logic        reset_n,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_rgb,
   output logic [7:0]  R_out,
   output logic [7:0]  G_out,
   output logic [7:0]  B_out,
   output logic        HSYNC_out,
   output logic        VSYNC_out,
   output logic        ENABLE_out,
   output logic        PCLK_out,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
);

   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BW      = $clog2(BAR_W + 1);
   localparam int GW      = $clog2(GRID + 1);
   localparam int X_START = H_SYNCLEN + H_BACKPORCH;
   localparam int Y_START = V_SYNCLEN + V_BACKPORCH;

   localparam logic [HW-1:0] X_BEG     = HW'(X_START);
   localparam logic [HW-1:0] X_LAST    = HW'(X_START + H_ACTIVE - 1);
   localparam logic [VW-1:0] Y_BEG     = VW'(Y_START);
   localparam logic [VW-1:0] Y_LAST    = VW'(Y_START + V_ACTIVE - 1);
   localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);
   localparam logic [GW-1:0] GRID_LAST = GW'(GRID - 1);

   logic [HW-1:0] w_h_cnt;
   logic [VW-1:0] w_v_cnt;
   logic          w_line_end;
   logic          w_frame_end;
   logic          w_active;

   patgen_timing #(
      .H_SYNCLEN   (H_SYNCLEN),
      .H_BACKPORCH (H_BACKPORCH),
      .H_ACTIVE    (H_ACTIVE),
      .H_TOTAL     (H_TOTAL),
      .V_SYNCLEN   (V_SYNCLEN),
      .V_BACKPORCH (V_BACKPORCH),
      .V_ACTIVE    (V_ACTIVE),
      .V_TOTAL     (V_TOTAL),
      .HSYNC_POL   (HSYNC_POL),
      .VSYNC_POL   (VSYNC_POL),
      .HW          (HW),
      .VW          (VW)
   ) u_timing (
      .i_clk         (clk27),
      .i_rst_n       (reset_n),
      .o_h_cnt       (w_h_cnt),
      .o_v_cnt       (w_v_cnt),
      .o_line_end    (w_line_end),
      .o_frame_end   (w_frame_end),
      .o_active      (w_active),
      .o_hsync       (HSYNC_out),
      .o_vsync       (VSYNC_out),
      .o_de          (ENABLE_out),
      .o_frame_start (frame_start),
      .o_frame_cnt   (frame_cnt)
   );

   assign PCLK_out = clk27;

   pat_e          r_mode;
   logic [23:0]   r_solid;
   logic [BW-1:0] r_bar_cnt;
   logic [2:0]    r_bar_idx;
   logic [GW-1:0] r_gx;
   logic [GW-1:0] r_gy;

   logic          w_h_ge;
   logic          w_v_ge;
   logic [15:0]   w_x;
   logic [7:0]    w_ramp;
   logic          w_hit;
   logic [23:0]   w_pix;

   assign w_h_ge = (w_h_cnt >= X_BEG);
   assign w_v_ge = (w_v_cnt >= Y_BEG);
   assign w_x    = 16'(w_h_cnt) - 16'(X_START);
   assign w_ramp = 8'(w_x >> RAMP_SHIFT);

   // Position counters track the live h/v state: they sit at 0 until the
   // active start and then advance, so no divider is needed for bars or grid.
   always_ff @(posedge clk27) begin
      if (!reset_n) begin
         r_mode    <= PAT_RAMP;
         r_solid   <= '0;
         r_bar_cnt <= '0;
         r_bar_idx <= '0;
         r_gx      <= '0;
         r_gy      <= '0;
      end else begin
         if (w_frame_end) begin
            r_mode  <= pat_e'(pattern_sel);
            r_solid <= solid_rgb;
         end
         if (w_line_end) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
            r_gx      <= '0;
         end else if (w_h_ge) begin
            if (r_bar_cnt == BAR_LAST) begin
               r_bar_cnt <= '0;
               if (r_bar_idx != 3'd7) begin
                  r_bar_idx <= r_bar_idx + 3'd1;
               end
            end else begin
               r_bar_cnt <= r_bar_cnt + 1'b1;
            end
            r_gx <= (r_gx == GRID_LAST) ? '0 : r_gx + 1'b1;
         end
         if (w_frame_end) begin
            r_gy <= '0;
         end else if (w_line_end && w_v_ge) begin
            r_gy <= (r_gy == GRID_LAST) ? '0 : r_gy + 1'b1;
         end
      end
   end

   assign w_hit = (r_gx == '0) || (r_gy == '0) || (w_h_cnt == X_LAST) || (w_v_cnt == Y_LAST);

   always_comb begin
      w_pix = '0;
      if (w_active) begin
         case (r_mode)
            PAT_RAMP:   w_pix = {3{w_ramp}};
            PAT_BARS:   w_pix = BAR_TABLE[r_bar_idx];
            PAT_SOLID:  w_pix = r_solid;
            PAT_XHATCH: w_pix = {24{w_hit}};
            default:    w_pix = '0;
         endcase
      end
   end

   logic [2:0][7:0] w_chan_q;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic [7:0] r_chan;
         always_ff @(posedge clk27) begin
            if (!reset_n) begin
               r_chan <= '0;
            end else begin
               r_chan <= w_pix[gi*8 +: 8];
            end
         end
         assign w_chan_q[gi] = r_chan;
      end
   endgenerate

   assign B_out = w_chan_q[0];
   assign G_out = w_chan_q[1];
   assign R_out = w_chan_q[2];

endmodule

// File: doc/patgen.md
PATGEN -- requirements
Module: patgen

Interface
REQ-001 Parameters SHALL be, one per line:
- H_SYNCLEN, 62, hsync width in pixels
- H_BACKPORCH, 60, pixels between sync end and active start
- H_ACTIVE, 720, active pixels per line
- H_TOTAL, 858, pixels per line
- V_SYNCLEN, 6, vsync width in lines
- V_BACKPORCH, 30, lines between vsync end and active start
- V_ACTIVE, 480, active lines
- V_TOTAL, 525, lines per frame
- HSYNC_POL / VSYNC_POL, 0, asserted level (0 = active-low)
- BAR_W, 90, colour-bar width in pixels
- GRID, 32, crosshatch pitch in pixels/lines
- RAMP_SHIFT, 1, right shift of x for ramp
REQ-002 Ports SHALL be, one per line:
- clk27  in  1  pixel clock, sole clock
- reset_n  in  1  synchronous, active-low reset
- pattern_sel  in  2  0 ramp, 1 colour bars, 2 solid, 3 crosshatch
- solid_rgb  in  24  {R,G,B} for mode 2
- R_out / G_out / B_out  out  8 each  pixel data
- HSYNC_out / VSYNC_out  out  1  syncs per polarity parameters
- ENABLE_out  out  1  data enable
- PCLK_out  out  1  equal to clk27
- frame_start  out  1  one-cycle pulse at frame origin
- frame_cnt  out  8  completed-frame counter

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1 and wrap; v_cnt SHALL increment only when h_cnt==H_TOTAL-1 and wrap from V_TOTAL-1 to 0.
REQ-004 X_START=H_SYNCLEN+H_BACKPORCH, Y_START=V_SYNCLEN+V_BACKPORCH; x=h_cnt-X_START, y=v_cnt-Y_START.
REQ-005 All outputs except PCLK_out SHALL be registered with exactly one cycle latency from the counter state; syncs, enable, data and frame_start SHALL be mutually aligned.
REQ-006 HSYNC_out SHALL be asserted iff h_cnt<H_SYNCLEN; VSYNC_out asserted iff v_cnt<V_SYNCLEN.
REQ-007 ENABLE_out SHALL be high iff X_START<=h_cnt<X_START+H_ACTIVE and Y_START<=v_cnt<Y_START+V_ACTIVE; RGB SHALL be 0 when ENABLE_out is low.
REQ-008 Mode 0: R=G=B=low 8 bits of (x>>RAMP_SHIFT).
REQ-009 Mode 1: bar index i=min(x/BAR_W,7), implemented with counters, no divider; R=~i[1], G=~i[2], B=~i[0], each bit expanded to 0xFF/0x00 (white, yellow, cyan, green, magenta, red, blue, black).
REQ-010 Mode 2: RGB=latched solid_rgb.
REQ-011 Mode 3: RGB=0xFFFFFF when x mod GRID==0, y mod GRID==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; else 0; moduli via counters.
REQ-012 pattern_sel and solid_rgb SHALL be sampled only in the cycle where h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1; a change mid-frame SHALL take effect from the next frame.
REQ-013 frame_start SHALL be high for one output cycle, the one reflecting h_cnt=0,v_cnt=0.
REQ-014 frame_cnt SHALL increment by 1 coincident with frame_start and wrap 255->0.

Reset
REQ-015 While reset_n is low at a clk27 edge: h_cnt=v_cnt=0, frame_cnt=0, latched mode=0, latched solid_rgb=0, RGB=0, ENABLE_out=0, frame_start=0, syncs deasserted (~POL).
REQ-016 Reset asserted mid-frame SHALL take effect at the next edge, regardless of counter state; the first cycle after release SHALL start counting from h_cnt=0,v_cnt=0.

Structure
REQ-017 Shared package SHALL hold default 720x480 timing constants, pattern_sel encodings and the 8-entry bar colour table.
REQ-018 Counter/sync/enable logic SHALL be one sub-module, patgen_timing; pattern logic stays in patgen.

Verification
REQ-019 reset_n low 5 cycles then high -> outputs at reset values; HSYNC_out low 62 of every 858 cycles.
REQ-020 Free run -> VSYNC_out low 5148 cycles per 450450-cycle frame; frame_start once per frame; frame_cnt 255->0 after 256 frames.
REQ-021 Mode 1 -> x=0 FFFFFF, x=90 FFFF00, x=359 00FF00, x=719 000000.
REQ-022 pattern_sel 0->2 with solid_rgb=123456 at v_cnt=200 -> remainder of frame stays ramp; first active pixel of next frame=123456.
REQ-023 Mode 3 -> (x0,y5) FFFFFF, (x5,y5) 000000, (x32,y5) FFFFFF, (x719,y5) FFFFFF, (x5,y479) FFFFFF.
REQ-024 reset_n low one cycle at h_cnt=400,v_cnt=300 -> next cycle reset values; counting resumes from 0,0.
